// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, EX redirect inputs and the
// valid/ready head interface towards ID. The master side is the fetch queue.
interface if_fetch_queue_if #(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32,
    parameter int DEPTH     = 4
) ();
    logic                       fetch_en;
    logic                       redirect_valid;
    logic                       redirect_sel;
    logic [WORD-1:0]            branch_target;
    logic [WORD-1:0]            reg_target;
    logic [WORD-1:0]            imem_addr;
    logic [INST_SIZE-1:0]       imem_inst;
    logic                       out_valid;
    logic                       out_ready;
    logic [INST_SIZE-1:0]       out_inst;
    logic [WORD-1:0]            out_pc;
    logic [WORD-1:0]            out_pc_incr;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        input  fetch_en, redirect_valid, redirect_sel, branch_target, reg_target,
        input  imem_inst, out_ready,
        output imem_addr, out_valid, out_inst, out_pc, out_pc_incr, count
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_sel, branch_target, reg_target,
        output imem_inst, out_ready,
        input  imem_addr, out_valid, out_inst, out_pc, out_pc_incr, count
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC generator feeding a DEPTH-entry prefetch queue.
// Each fetched instruction is stored with its PC; ID drains the queue through
// a valid/ready handshake, and an EX redirect flushes it and reloads the PC.
module if_fetch_queue #(
    parameter int              WORD      = 64,
    parameter int              INST_SIZE = 32,
    parameter int              DEPTH     = 4,
    parameter logic [WORD-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    if_fetch_queue_if.master   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WORD-1:0]      fpc;
    logic [INST_SIZE-1:0] q_inst [DEPTH];
    logic [WORD-1:0]      q_pc   [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        occ;

    logic                 valid;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic [WORD-1:0]      redirect_pc;
    logic [WORD-1:0]      head_pc;

    assign valid = (occ != '0);
    assign full  = (occ == CW'(DEPTH));
    assign pop   = valid & bus.out_ready;
    // A full queue still accepts a new entry when the head leaves this cycle.
    assign push  = bus.fetch_en & ~bus.redirect_valid & (~full | pop);

    assign redirect_pc = (bus.redirect_sel ? bus.reg_target : bus.branch_target)
                         & {{(WORD-2){1'b1}}, 2'b00};

    assign bus.imem_addr = fpc;

    // PC, pointers and occupancy; redirect flushes and outranks push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc    <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (bus.redirect_valid) begin
            fpc    <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                fpc    <= fpc + WORD'(4);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Queue storage; contents need no reset since outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= bus.imem_inst;
            q_pc[wr_ptr]   <= fpc;
        end
    end

    // Head-of-queue output mux, forced to zero while empty.
    always_comb begin
        head_pc      = '0;
        bus.out_inst = '0;
        if (valid) begin
            head_pc      = q_pc[rd_ptr];
            bus.out_inst = q_inst[rd_ptr];
        end
    end

    assign bus.out_valid   = valid;
    assign bus.out_pc      = head_pc;
    assign bus.out_pc_incr = valid ? head_pc + WORD'(4) : '0;
    assign bus.count       = occ;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, back-pressure, redirect,
// fetch-disable, PC wrap-around and asynchronous reset.
module tb_if_fetch_queue;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    if_fetch_queue_if #(.WORD(64), .INST_SIZE(32), .DEPTH(4)) b1 ();
    if_fetch_queue_if #(.WORD(64), .INST_SIZE(32), .DEPTH(4)) b2 ();

    if_fetch_queue #(.WORD(64), .INST_SIZE(32), .DEPTH(4), .RESET_PC(64'h0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.master)
    );

    if_fetch_queue #(.WORD(64), .INST_SIZE(32), .DEPTH(4),
                     .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.master)
    );

    // Instruction memory returns the low address bits as the instruction.
    assign b1.imem_inst = b1.imem_addr[31:0];
    assign b2.imem_inst = b2.imem_addr[31:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        b1.fetch_en = 1'b0; b1.out_ready = 1'b0; b1.redirect_valid = 1'b0;
        b1.redirect_sel = 1'b0; b1.branch_target = '0; b1.reg_target = '0;
        b2.fetch_en = 1'b1; b2.out_ready = 1'b1; b2.redirect_valid = 1'b0;
        b2.redirect_sel = 1'b0; b2.branch_target = '0; b2.reg_target = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(b1.out_valid), 64'h0);
        chk("rst_count", 64'(b1.count), 64'h0);
        chk("rst_imem", b1.imem_addr, 64'h0);
        chk("rst_pc", b1.out_pc, 64'h0);
        chk("rst_incr", b1.out_pc_incr, 64'h0);
        chk("rst_wrap_imem", b2.imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        tick();

        // Streaming with out_ready high: one instruction per cycle.
        rst_n = 1'b1;
        b1.fetch_en = 1'b1;
        b1.out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("stream_pc", b1.out_pc, 64'(4 * (k - 1)));
            chk("stream_inst", 64'(b1.out_inst), 64'(4 * (k - 1)));
            chk("stream_incr", b1.out_pc_incr, 64'(4 * k));
            chk("stream_count", 64'(b1.count), 64'h1);
            chk("stream_imem", b1.imem_addr, 64'(4 * k));
            if (k == 1) begin
                chk("wrap_pc0", b2.out_pc, 64'hFFFF_FFFF_FFFF_FFF8);
                chk("wrap_incr0", b2.out_pc_incr, 64'hFFFF_FFFF_FFFF_FFFC);
            end
            if (k == 2) begin
                chk("wrap_pc1", b2.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
                chk("wrap_incr1", b2.out_pc_incr, 64'h0);
            end
            if (k == 3) begin
                chk("wrap_pc2", b2.out_pc, 64'h0);
                chk("wrap_incr2", b2.out_pc_incr, 64'h4);
            end
        end

        // Mid-stream asynchronous reset with two entries queued.
        b1.out_ready = 1'b0;
        tick();
        chk("pre_rst_count", 64'(b1.count), 64'h2);
        chk("pre_rst_pc", b1.out_pc, 64'h14);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(b1.out_valid), 64'h0);
        chk("arst_count", 64'(b1.count), 64'h0);
        chk("arst_pc", b1.out_pc, 64'h0);
        chk("arst_inst", 64'(b1.out_inst), 64'h0);
        chk("arst_incr", b1.out_pc_incr, 64'h0);
        chk("arst_imem", b1.imem_addr, 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Back-pressure: queue fills to DEPTH, fetch PC stalls at 0x10.
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("bp_count", 64'(b1.count), 64'((k < 4) ? k : 4));
            chk("bp_head_pc", b1.out_pc, 64'h0);
            chk("bp_head_inst", 64'(b1.out_inst), 64'h0);
            chk("bp_imem", b1.imem_addr, 64'(4 * ((k < 4) ? k : 4)));
        end
        b1.out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("drain_pc", b1.out_pc, 64'(4 * j));
            chk("drain_count", 64'(b1.count), 64'h4);
            chk("drain_imem", b1.imem_addr, 64'(16 + 4 * j));
        end

        // Pop without push leaves three entries.
        b1.fetch_en = 1'b0;
        tick();
        chk("three_count", 64'(b1.count), 64'h3);
        chk("three_pc", b1.out_pc, 64'h14);
        chk("three_imem", b1.imem_addr, 64'h20);

        // Branch redirect coinciding with a pop; low target bits dropped.
        b1.fetch_en = 1'b1;
        b1.redirect_valid = 1'b1;
        b1.redirect_sel = 1'b0;
        b1.branch_target = 64'h103;
        b1.reg_target = 64'h7770;
        tick();
        chk("br_count", 64'(b1.count), 64'h0);
        chk("br_valid", 64'(b1.out_valid), 64'h0);
        chk("br_imem", b1.imem_addr, 64'h100);
        chk("br_pc", b1.out_pc, 64'h0);
        b1.redirect_valid = 1'b0;
        tick();
        chk("br_head_pc", b1.out_pc, 64'h100);
        chk("br_head_inst", 64'(b1.out_inst), 64'h100);
        chk("br_head_valid", 64'(b1.out_valid), 64'h1);
        chk("br_head_count", 64'(b1.count), 64'h1);

        // Register redirect while fetch disabled: PC loads, nothing pushed.
        b1.out_ready = 1'b0;
        b1.fetch_en = 1'b0;
        b1.redirect_valid = 1'b1;
        b1.redirect_sel = 1'b1;
        b1.reg_target = 64'h2000;
        b1.branch_target = 64'h555;
        tick();
        chk("reg_count", 64'(b1.count), 64'h0);
        chk("reg_imem", b1.imem_addr, 64'h2000);
        b1.redirect_valid = 1'b0;
        tick();
        chk("hold_count", 64'(b1.count), 64'h0);
        chk("hold_valid", 64'(b1.out_valid), 64'h0);
        chk("hold_imem", b1.imem_addr, 64'h2000);
        b1.fetch_en = 1'b1;
        tick();
        chk("reg_head_pc", b1.out_pc, 64'h2000);
        chk("reg_head_incr", b1.out_pc_incr, 64'h2004);
        chk("reg_head_count", 64'(b1.count), 64'h1);
        chk("reg_next_imem", b1.imem_addr, 64'h2004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
